// File: rtl/mac_psum_ctrl.sv
// mac_psum_ctrl: partial-sum responder for the MAC array.
// Holds one saturated partial sum per lane and supplies it as the MAC C operand.
// It captures each MAC result and, after the programmed number of passes,
// presents the finished tile (optionally ReLU-clamped) on a valid/ready port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start                    begin a new tile (IDLE only)
//   i_num_pass, i_relu_en      tile configuration, latched at start
//   i_mac_issue                one pass issued to the MAC this cycle
//   i_partial_output_prepare   MAC samples o_partial_output on the next edge
//   i_result_vld, i_result     MAC result strobe and per-lane results
//   o_partial_output           per-lane C operand
//   o_pass_rdy, o_busy         pass issue permission, tile in progress
//   o_out_data, o_out_vld      finished tile, held until i_out_rdy
//   i_out_rdy                  downstream accept
//   o_sat_flag                 sticky per tile: a lane saturated
//   o_err                      sticky until reset: protocol violation
module mac_psum_ctrl #(
    parameter int unsigned LANES  = 120,
    parameter int unsigned PSUM_W = 28,
    parameter int unsigned RES_W  = 33
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [7:0]                i_num_pass,
    input  logic                      i_relu_en,
    input  logic                      i_mac_issue,
    input  logic                      i_partial_output_prepare,
    input  logic                      i_result_vld,
    input  logic [LANES*RES_W-1:0]    i_result,
    output logic [LANES*PSUM_W-1:0]   o_partial_output,
    output logic                      o_pass_rdy,
    output logic                      o_busy,
    output logic [LANES*PSUM_W-1:0]   o_out_data,
    output logic                      o_out_vld,
    input  logic                      i_out_rdy,
    output logic                      o_sat_flag,
    output logic                      o_err
);

    localparam int unsigned PV_W = LANES * PSUM_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic signed [RES_W-1:0] C_SAT_MAX = RES_W'({1'b0, {(PSUM_W-1){1'b1}}});
    localparam logic signed [RES_W-1:0] C_SAT_MIN = {{(RES_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_in_flight;
    logic            w_in_flight_nxt;
    logic [7:0]      r_pass_cnt;
    logic [7:0]      r_num_pass;
    logic            r_relu_en;
    logic [PV_W-1:0] r_psum;
    logic [PV_W-1:0] r_out_data;
    logic            r_out_vld;
    logic            r_sat_flag;
    logic            r_err;
    logic            r_pass_rdy;
    logic            r_busy;

    logic            w_start_ok;
    logic            w_issue_ok;
    logic            w_capture;
    logic            w_last;
    logic            w_done;
    logic            w_err_set;
    logic [PV_W-1:0] w_sat_vec;
    logic [PV_W-1:0] w_relu_vec;
    logic [LANES-1:0] w_clamp;
    logic            w_unused_prepare;

    // C operand is presented continuously from registers, so the prepare strobe needs no action.
    assign w_unused_prepare = i_partial_output_prepare;

    // Per-lane saturation of the MAC result into the partial-sum range, plus ReLU view.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [RES_W-1:0]  w_res;
        logic signed [PSUM_W-1:0] w_sat;
        logic                     w_hi;
        logic                     w_lo;
        assign w_res = i_result[g*RES_W +: RES_W];
        assign w_hi  = (w_res > C_SAT_MAX);
        assign w_lo  = (w_res < C_SAT_MIN);
        assign w_sat = w_hi ? {1'b0, {(PSUM_W-1){1'b1}}} :
                       w_lo ? {1'b1, {(PSUM_W-1){1'b0}}} : w_res[PSUM_W-1:0];
        assign w_clamp[g] = w_hi | w_lo;
        assign w_sat_vec[g*PSUM_W +: PSUM_W]  = w_sat;
        assign w_relu_vec[g*PSUM_W +: PSUM_W] = w_sat[PSUM_W-1] ? '0 : w_sat;
    end

    // Next-state, event decode and in-flight tracking.
    always_comb begin
        w_state_nxt     = r_state;
        w_in_flight_nxt = r_in_flight;
        w_start_ok      = (r_state == S_IDLE) && i_start;
        w_issue_ok      = i_mac_issue && r_pass_rdy;
        w_capture       = i_result_vld && (r_state == S_ACCUM) && r_in_flight;
        w_last          = w_capture && (r_pass_cnt == (r_num_pass - 8'd1));
        w_done          = (r_state == S_DRAIN) && r_out_vld && i_out_rdy;
        w_err_set       = (i_mac_issue && !r_pass_rdy) || (i_result_vld && !w_capture);

        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_last)     w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_done)     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_capture)  w_in_flight_nxt = 1'b0;
        if (w_issue_ok) w_in_flight_nxt = 1'b1;
    end

    // State and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_flight <= 1'b0;
            r_pass_rdy  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_flight <= w_in_flight_nxt;
            r_pass_rdy  <= (w_state_nxt == S_ACCUM) && !w_in_flight_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_err       <= r_err | w_err_set;
        end
    end

    // Tile datapath: configuration latch, partial sums, drain register.
    // Clearing psum at start makes it double as the C operand (zero on the first pass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_pass <= 8'd1;
            r_relu_en  <= 1'b0;
            r_pass_cnt <= 8'd0;
            r_psum     <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_num_pass <= (i_num_pass == 8'd0) ? 8'd1 : i_num_pass;
                r_relu_en  <= i_relu_en;
                r_pass_cnt <= 8'd0;
                r_psum     <= '0;
                r_sat_flag <= 1'b0;
            end
            if (w_capture) begin
                r_psum     <= w_sat_vec;
                r_pass_cnt <= r_pass_cnt + 8'd1;
                if (|w_clamp) r_sat_flag <= 1'b1;
            end
            if (w_last) begin
                r_out_data <= r_relu_en ? w_relu_vec : w_sat_vec;
                r_out_vld  <= 1'b1;
            end
            if (w_done) r_out_vld <= 1'b0;
        end
    end

    assign o_partial_output = r_psum;
    assign o_pass_rdy       = r_pass_rdy;
    assign o_busy           = r_busy;
    assign o_out_data       = r_out_data;
    assign o_out_vld        = r_out_vld;
    assign o_sat_flag       = r_sat_flag;
    assign o_err            = r_err;

endmodule
